mem_access: RTL and testbench

//  EX/MEM -> MEM/WB stage. Consumes execute-stage outputs, runs the data-memory
//  req/ready handshake (byte/half/word, sign/zero extension), resolves branches

---
 rtl/mem_access.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: EX/MEM -> MEM/WB stage. Runs the data-memory req/ready handshake,
// extracts and extends load data, resolves branches and registers the
// write-back bundle. mem_stall holds the upstream stages while an access is
// outstanding.
module mem_access #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] PCBranch_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [31:0] read_data2_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [31:0] Instraction_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] WB_data_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          we_q, uns_q;
    logic [1:0]    lane_q, size_q;

    // Only the load-unsigned and store-size fields of the instruction matter here.
    logic unused_instr;
    assign unused_instr = ^{Instraction_pype2[31:15], Instraction_pype2[11:0]};

    logic        mem_op, is_st, misal, issue, timeout_hit;
    logic [1:0]  acc_size, lane, ld_size;
    logic        ld_uns;
    logic [31:0] wdata_live, ld_data, wb_data;
    logic [3:0]  be_live;

    assign mem_op   = (MemRW_pype2 == 2'b01) || (MemRW_pype2 == 2'b10);
    assign is_st    = (MemRW_pype2 == 2'b10);
    assign acc_size = is_st ? Instraction_pype2[13:12] : dsize_pype2;
    assign misal    = ((acc_size == 2'b01) && ALU_co_pype[0]) ||
                      (acc_size[1] && (ALU_co_pype[1:0] != 2'b00));
    assign issue    = (state == IDLE) && mem_op && !misal && !keep && !nop && !rst;
    assign timeout_hit = (state == WAIT) && !dmem_ready && (cnt == CNT_LAST);

    // Store lane steering; reads always fetch the whole word.
    always_comb begin
        be_live    = 4'b1111;
        wdata_live = read_data2_pype2;
        case (Instraction_pype2[13:12])
            2'b00: begin
                wdata_live = {4{read_data2_pype2[7:0]}};
                if (is_st) be_live = 4'b0001 << ALU_co_pype[1:0];
            end
            2'b01: begin
                wdata_live = {2{read_data2_pype2[15:0]}};
                if (is_st) be_live = 4'b0011 << {ALU_co_pype[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Handshake FSM next state and bus drive; WAIT replays the latched request.
    always_comb begin
        state_nx   = state;
        dmem_req   = 1'b0;
        dmem_we    = is_st;
        dmem_addr  = {ALU_co_pype[31:2], 2'b00};
        dmem_wdata = wdata_live;
        dmem_be    = be_live;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        state_nx  = WAIT;
                        mem_stall = 1'b1;
                    end
                end
            end
            WAIT: begin
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                dmem_be    = be_q;
                if (!rst) begin
                    dmem_req = 1'b1;
                    // Timeout releases the pipe so the aborted access is not reissued.
                    if (dmem_ready || timeout_hit) state_nx = IDLE;
                    else                           mem_stall = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        lane    = (state == WAIT) ? lane_q : ALU_co_pype[1:0];
        ld_size = (state == WAIT) ? size_q : dsize_pype2;
        ld_uns  = (state == WAIT) ? uns_q  : Instraction_pype2[14];
        ld_data = dmem_rdata;
        case (ld_size)
            2'b00: begin
                ld_data[7:0]  = dmem_rdata[8*lane +: 8];
                ld_data[31:8] = {24{!ld_uns && ld_data[7]}};
            end
            2'b01: begin
                ld_data[15:0]  = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
                ld_data[31:16] = {16{!ld_uns && ld_data[15]}};
            end
            default: ;
        endcase
    end

    // Write-back select; the WB-side controls stay valid in WAIT because upstream is stalled.
    always_comb begin
        case (MemtoReg_pype2)
            2'b00:   wb_data = ALU_co_pype;
            2'b01:   wb_data = ld_data;
            2'b10:   wb_data = PCp4_pype2;
            default: wb_data = 32'd0;
        endcase
    end

    // Branch resolution from the ALU result; suppressed while the stage is not advancing.
    always_comb begin
        case (MemBranch_pype2)
            3'b001:         branch_taken = (ALU_co_pype == 32'd0);
            3'b010:         branch_taken = (ALU_co_pype != 32'd0);
            3'b011:         branch_taken = ALU_co_pype[0];
            3'b100:         branch_taken = !ALU_co_pype[0];
            3'b110, 3'b111: branch_taken = 1'b1;
            default:        branch_taken = 1'b0;
        endcase
        branch_taken = branch_taken && !mem_stall && !keep && !rst;
    end
    assign branch_target = PCBranch_pype2;

    // State, timeout counter, request capture and pype3 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus_err        <= 1'b0;
            misalign_err   <= 1'b0;
            WB_data_pype3  <= 32'd0;
            WReg_pype3     <= 5'd0;
            RegWrite_pype3 <= 1'b0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            be_q           <= 4'd0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            lane_q         <= 2'd0;
            size_q         <= 2'd0;
        end else begin
            state        <= state_nx;
            misalign_err <= 1'b0;
            if (issue) begin
                addr_q  <= dmem_addr;
                wdata_q <= wdata_live;
                be_q    <= be_live;
                we_q    <= is_st;
                uns_q   <= Instraction_pype2[14];
                lane_q  <= ALU_co_pype[1:0];
                size_q  <= dsize_pype2;
            end
            if (state == WAIT) begin
                if (dmem_ready) begin
                    cnt            <= '0;
                    WB_data_pype3  <= wb_data;
                    WReg_pype3     <= WReg_pype2;
                    RegWrite_pype3 <= RegWrite_pype2;
                end else begin
                    // Bubble while waiting; on timeout the access is dropped.
                    cnt            <= timeout_hit ? '0 : cnt + 1'b1;
                    bus_err        <= bus_err | timeout_hit;
                    WB_data_pype3  <= 32'd0;
                    WReg_pype3     <= 5'd0;
                    RegWrite_pype3 <= 1'b0;
                end
            end else if (keep) begin
                // hold pype3
            end else if (nop || (issue && !dmem_ready)) begin
                WB_data_pype3  <= 32'd0;
                WReg_pype3     <= 5'd0;
                RegWrite_pype3 <= 1'b0;
            end else begin
                WB_data_pype3  <= wb_data;
                WReg_pype3     <= WReg_pype2;
                RegWrite_pype3 <= RegWrite_pype2 && !(mem_op && misal);
                misalign_err   <= mem_op && misal;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed + randomized checks of the memory-access stage
// against a byte-level reference model.
module tb_mem_access;

    logic        clk, rst, keep, nop;
    logic [31:0] ALU_co_pype, PCBranch_pype2, PCp4_pype2, read_data2_pype2;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2, dsize_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [31:0] Instraction_pype2;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, branch_taken;
    logic [31:0] branch_target, WB_data_pype3;
    logic [4:0]  WReg_pype3;
    logic        RegWrite_pype3, misalign_err, bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .ALU_co_pype(ALU_co_pype), .PCBranch_pype2(PCBranch_pype2),
        .PCp4_pype2(PCp4_pype2), .read_data2_pype2(read_data2_pype2),
        .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .MemBranch_pype2(MemBranch_pype2), .dsize_pype2(dsize_pype2),
        .Instraction_pype2(Instraction_pype2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .WB_data_pype3(WB_data_pype3), .WReg_pype3(WReg_pype3),
        .RegWrite_pype3(RegWrite_pype3), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: pick nbytes starting at byte 'lane', then extend.
    function automatic logic [31:0] ld_ref(logic [31:0] w, int lane, int nbytes, bit uns);
        logic [63:0] v;
        v = (64'(w) >> (8 * lane)) & ((64'd1 << (8 * nbytes)) - 64'd1);
        if (!uns && (((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1))
            v = v - (64'd1 << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic [3:0] be_ref(bit st, int lane, int nbytes);
        logic [3:0] be;
        be = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (!st || (b >= lane && b < lane + nbytes)) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] wd_ref(logic [31:0] d, int nbytes);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(d >> (8 * (b % nbytes)));
        return w;
    endfunction

    task automatic idle_inputs();
        MemRW_pype2 = 2'b00; MemBranch_pype2 = 3'b000; MemtoReg_pype2 = 2'b00;
        RegWrite_pype2 = 1'b0; dmem_ready = 1'b0;
    endtask

    // One memory access; ready arrives 'delay' cycles after issue.
    task automatic mem_op(input bit st, input int size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] rdata, input int delay,
                          input logic [4:0] wreg);
        int nb, lane;
        nb = 1 << size;
        lane = int'(addr[1:0]);
        ALU_co_pype = addr; read_data2_pype2 = d; dmem_rdata = rdata;
        MemRW_pype2 = st ? 2'b10 : 2'b01; MemtoReg_pype2 = st ? 2'b00 : 2'b01;
        RegWrite_pype2 = !st; WReg_pype2 = wreg; dsize_pype2 = 2'(size);
        Instraction_pype2 = (32'(uns) << 14) | (32'(size) << 12);
        MemBranch_pype2 = 3'b000;
        for (int k = 0; k <= delay; k++) begin
            dmem_ready = (k == delay);
            #1;
            check("req", 32'(dmem_req), 32'd1);
            check("we", 32'(dmem_we), 32'(st));
            check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("be", 32'(dmem_be), 32'(be_ref(st, lane, nb)));
            if (st) check("wdata", dmem_wdata, wd_ref(d, nb));
            check("stall", 32'(mem_stall), 32'(k < delay));
            @(negedge clk);
        end
        check("wb_data", WB_data_pype3, st ? addr : ld_ref(rdata, lane, nb, uns));
        check("regwrite", 32'(RegWrite_pype3), 32'(!st));
        check("wreg", 32'(WReg_pype3), 32'(wreg));
        idle_inputs();
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [31:0] pc4, input logic [1:0] sel,
                          input logic [4:0] wreg);
        ALU_co_pype = alu; PCp4_pype2 = pc4; MemtoReg_pype2 = sel;
        MemRW_pype2 = 2'b00; RegWrite_pype2 = 1'b1; WReg_pype2 = wreg;
        #1;
        check("alu_stall", 32'(mem_stall), 32'd0);
        check("alu_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("alu_wb", WB_data_pype3, sel == 2'b00 ? alu : sel == 2'b10 ? pc4 : 32'd0);
        check("alu_wreg", 32'(WReg_pype3), 32'(wreg));
        idle_inputs();
    endtask

    task automatic br_op(input logic [2:0] kind, input logic [31:0] alu, input logic [31:0] tgt);
        bit exp;
        case (kind)
            3'b001: exp = (alu == 0);
            3'b010: exp = (alu != 0);
            3'b011: exp = (alu % 2 == 1);
            3'b100: exp = (alu % 2 == 0);
            3'b110, 3'b111: exp = 1;
            default: exp = 0;
        endcase
        MemBranch_pype2 = kind; ALU_co_pype = alu; PCBranch_pype2 = tgt; MemRW_pype2 = 2'b00;
        #1;
        check("br_taken", 32'(branch_taken), 32'(exp));
        check("br_target", branch_target, tgt);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        int c;
        rst = 1'b1; keep = 1'b0; nop = 1'b0;
        ALU_co_pype = 0; PCBranch_pype2 = 0; PCp4_pype2 = 0; read_data2_pype2 = 0;
        WReg_pype2 = 0; dsize_pype2 = 0; Instraction_pype2 = 0; dmem_rdata = 0;
        idle_inputs();
        @(negedge clk); @(negedge clk);
        check("rst_wb", WB_data_pype3, 32'd0);
        check("rst_regwrite", 32'(RegWrite_pype3), 32'd0);
        check("rst_wreg", 32'(WReg_pype3), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed accesses
        mem_op(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 5'd3);
        mem_op(0, 0, 0, 32'h103, 0, 32'h80112233, 0, 5'd4);
        check("lb_sext", WB_data_pype3, 32'hFFFFFF80);
        mem_op(0, 0, 1, 32'h103, 0, 32'h80112233, 0, 5'd4);
        check("lbu_zext", WB_data_pype3, 32'h00000080);
        mem_op(1, 1, 0, 32'h102, 32'h0000ABCD, 0, 3, 5'd0);

        // Misaligned word load
        MemRW_pype2 = 2'b01; dsize_pype2 = 2'b10; ALU_co_pype = 32'h101;
        RegWrite_pype2 = 1'b1; MemtoReg_pype2 = 2'b01; Instraction_pype2 = 32'h2000;
        #1;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_regwrite", 32'(RegWrite_pype3), 32'd0);
        idle_inputs();
        @(negedge clk);
        check("mis_pulse_end", 32'(misalign_err), 32'd0);

        // Branches
        br_op(3'b010, 32'd5, 32'h2000);
        br_op(3'b001, 32'd5, 32'h2000);

        // Randomized mix against the reference model
        for (int i = 0; i < 60; i++) begin
            int r, sz;
            logic [31:0] a;
            r = $urandom_range(0, 3);
            sz = $urandom_range(0, 2);
            a = ($urandom() & 32'h0000_FFFC) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
            case (r)
                0: mem_op(0, sz, 1'($urandom_range(0, 1)), a, 0, $urandom(),
                          $urandom_range(0, 3), 5'($urandom_range(1, 31)));
                1: mem_op(1, sz, 0, a, $urandom(), 0, $urandom_range(0, 3), 5'd0);
                2: alu_op($urandom(), $urandom(), ($urandom_range(0, 2) == 0) ? 2'b11 :
                          ($urandom_range(0, 1) == 0 ? 2'b00 : 2'b10), 5'($urandom_range(1, 31)));
                default: br_op(3'($urandom_range(0, 7)),
                               ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom(), $urandom());
            endcase
        end

        // keep: hold pype3, no request, no branch
        alu_op(32'h1234, 0, 2'b00, 5'd7);
        keep = 1'b1;
        MemRW_pype2 = 2'b01; dsize_pype2 = 2'b10; ALU_co_pype = 32'h40; RegWrite_pype2 = 1'b1;
        MemBranch_pype2 = 3'b110; dmem_ready = 1'b1;
        #1;
        check("keep_req", 32'(dmem_req), 32'd0);
        check("keep_branch", 32'(branch_taken), 32'd0);
        @(negedge clk);
        check("keep_wb", WB_data_pype3, 32'h1234);
        check("keep_wreg", 32'(WReg_pype3), 32'd7);
        keep = 1'b0;

        // nop: bubble, no request
        nop = 1'b1; MemBranch_pype2 = 3'b000;
        #1;
        check("nop_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("nop_wb", WB_data_pype3, 32'd0);
        check("nop_regwrite", 32'(RegWrite_pype3), 32'd0);
        nop = 1'b0;
        idle_inputs();

        // Reset in WAIT aborts the access
        MemRW_pype2 = 2'b01; dsize_pype2 = 2'b10; ALU_co_pype = 32'h300; Instraction_pype2 = 32'h2000;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("wait_req", 32'(dmem_req), 32'd1);
        check("wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wait_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        @(negedge clk);
        check("post_rst_req", 32'(dmem_req), 32'd0);
        mem_op(0, 2, 0, 32'h404, 0, 32'h12345678, 0, 5'd9);

        // Timeout: ready never comes
        MemRW_pype2 = 2'b01; dsize_pype2 = 2'b10; ALU_co_pype = 32'h200;
        RegWrite_pype2 = 1'b1; MemtoReg_pype2 = 2'b01; Instraction_pype2 = 32'h2000;
        #1;
        check("to_req", 32'(dmem_req), 32'd1);
        c = 0;
        while (!bus_err && c < 200) begin
            @(negedge clk);
            c++;
        end
        idle_inputs();
        check("to_cycles", 32'(c), 32'd65);
        check("to_regwrite", 32'(RegWrite_pype3), 32'd0);
        @(negedge clk); @(negedge clk);
        check("buserr_sticky", 32'(bus_err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("buserr_clear", 32'(bus_err), 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
